// File: rtl/seq_bin_to_bcd.sv
// seq_bin_to_bcd: multi-cycle binary-to-BCD converter (shift-and-add-3).
// One input bit is consumed per clock. A start/busy/done handshake frames each
// conversion, and the result registers hold their value until the next completion.
// Optional macro SIGNED_INPUT_EN: treat bin as two's complement, convert its
// magnitude and report the sign on neg. Without it, neg is tied low.
module seq_bin_to_bcd #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic                  neg
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [BIN_W-1:0] r_sr;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf_acc;
  logic [ACC_W-1:0] r_bcd;
  logic             r_ovf;

  logic [ACC_W-1:0] w_acc_adj;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [BIN_W-1:0] w_sr_nxt;
  logic             w_ovf_nxt;
  logic [BIN_W-1:0] w_load;

`ifdef SIGNED_INPUT_EN
  logic r_neg_cap;
  logic r_neg;

  // Magnitude in BIN_W unsigned bits, so the most-negative value maps to 2^(BIN_W-1).
  assign w_load = bin[BIN_W-1] ? ((~bin) + BIN_W'(1)) : bin;
  assign neg    = r_neg;
`else
  assign w_load = bin;
  assign neg    = 1'b0;
`endif

  // Add 3 to every digit >= 5, then shift the next operand bit into the accumulator.
  always_comb begin
    w_acc_adj = r_acc;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (r_acc[4*d +: 4] >= 4'd5) begin
        w_acc_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
      end
    end
    w_acc_nxt = {w_acc_adj[ACC_W-2:0], r_sr[BIN_W-1]};
    w_sr_nxt  = {r_sr[BIN_W-2:0], 1'b0};
    w_ovf_nxt = r_ovf_acc | w_acc_adj[ACC_W-1];
  end

  // Control FSM, datapath shift and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_sr      <= '0;
      r_acc     <= '0;
      r_ovf_acc <= 1'b0;
      r_bcd     <= '0;
      r_ovf     <= 1'b0;
`ifdef SIGNED_INPUT_EN
      r_neg_cap <= 1'b0;
      r_neg     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_FIN: begin
          if (start) begin
            r_sr      <= w_load;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf_acc <= 1'b0;
`ifdef SIGNED_INPUT_EN
            r_neg_cap <= bin[BIN_W-1];
`endif
            r_state   <= S_CONV;
          end else begin
            r_state   <= S_IDLE;
          end
        end
        S_CONV: begin
          r_acc     <= w_acc_nxt;
          r_sr      <= w_sr_nxt;
          r_ovf_acc <= w_ovf_nxt;
          r_cnt     <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST) begin
            r_bcd   <= w_acc_nxt;
            r_ovf   <= w_ovf_nxt;
`ifdef SIGNED_INPUT_EN
            r_neg   <= r_neg_cap;
`endif
            r_state <= S_FIN;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = (r_state == S_CONV);
  assign done     = (r_state == S_FIN);
  assign bcd      = r_bcd;
  assign overflow = r_ovf;

endmodule
